// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the ALU control pipeline and its opcode translator.
package alu_ctrl_pkg;

  localparam logic [3:0] CLS_RTYPE = 4'b0000;
  localparam logic [3:0] CLS_JMP   = 4'b0100;
  localparam logic [3:0] CLS_SHIFT = 4'b1000;
  localparam logic [3:0] CLS_LUI   = 4'b1111;

  // Low nibbles of the jump opcodes (JAL / JMP) that collapse to an add.
  localparam logic [3:0] JMP_LO_JAL = 4'b1100;
  localparam logic [3:0] JMP_LO_JMP = 4'b1000;

  localparam logic [7:0] DEF_ADDU_CODE = 8'h06;
  localparam logic [3:0] DEF_MD_CLASS  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/alu_control_pipe_if.sv
// Decode-to-ALU opcode channel: upstream valid/ready, downstream valid/ready, flush and busy.
interface alu_control_pipe_if #(
  parameter int OPW = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] opcode;
  logic           flush;
  logic           out_valid;
  logic           out_ready;
  logic [OPW-1:0] alu_opcode;
  logic           out_multi;
  logic           busy;

  // The pipeline block is the slave; decode/ALU side (or a bench) is the master.
  modport slave (
    input  in_valid, opcode, flush, out_ready,
    output in_ready, out_valid, alu_opcode, out_multi, busy
  );

  modport master (
    output in_valid, opcode, flush, out_ready,
    input  in_ready, out_valid, alu_opcode, out_multi, busy
  );
endinterface

// File: rtl/alu_opcode_xlate.sv
// Combinational instruction-opcode to ALU-opcode translation; also flags multi-cycle ops.
module alu_opcode_xlate
  import alu_ctrl_pkg::*;
#(
  parameter int             OPW       = 8,
  parameter logic [OPW-1:0] ADDU_CODE = OPW'(DEF_ADDU_CODE),
  parameter logic [3:0]     MD_CLASS  = DEF_MD_CLASS
) (
  input  logic [OPW-1:0] opcode,
  output logic [OPW-1:0] alu_opcode,
  output logic           is_multi
);

  logic [3:0] hi;
  logic [3:0] lo;

  assign hi = opcode[OPW-1 -: 4];
  assign lo = opcode[3:0];

  // Rule order matters: a MD_CLASS that aliases a fixed class loses to it.
  always_comb begin
    alu_opcode = opcode;
    is_multi   = 1'b0;
    if (hi == CLS_RTYPE) begin
      alu_opcode = opcode;
    end else if (hi == CLS_JMP) begin
      if (lo == JMP_LO_JAL || lo == JMP_LO_JMP) begin
        alu_opcode = ADDU_CODE;
      end
    end else if (hi == CLS_SHIFT || hi == CLS_LUI) begin
      alu_opcode = opcode;
    end else if (hi == MD_CLASS) begin
      is_multi = 1'b1;
    end else begin
      alu_opcode = {{(OPW-4){1'b0}}, hi};
    end
  end

endmodule

// File: rtl/alu_control_pipe.sv
// Handshaked ALU control stage: registers translated opcodes and blocks issue during mul/div busy windows.
module alu_control_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int             OPW       = 8,
  parameter logic [OPW-1:0] ADDU_CODE = OPW'(DEF_ADDU_CODE),
  parameter logic [3:0]     MD_CLASS  = DEF_MD_CLASS,
  parameter int             MD_CYCLES = 4
) (
  input  logic                clock,
  input  logic                reset,
  alu_control_pipe_if.slave   bus
);

  state_t         state_p1;
  logic [7:0]     cnt_p1;
  logic           vld_p1;
  logic           busy_p1;
  logic           multi_p1;
  logic [OPW-1:0] alu_p1;

  logic [OPW-1:0] xlate_p0;
  logic           multi_p0;
  logic           ready_p0;
  logic           accept_p0;

  // ---- stage p0: translate and decide acceptance ----
  alu_opcode_xlate #(
    .OPW       (OPW),
    .ADDU_CODE (ADDU_CODE),
    .MD_CLASS  (MD_CLASS)
  ) u_xlate (
    .opcode     (bus.opcode),
    .alu_opcode (xlate_p0),
    .is_multi   (multi_p0)
  );

  // A held multi op must hand off and drain its busy window before the next issue.
  assign ready_p0  = !bus.flush && (state_p1 != WAIT) &&
                     ((state_p1 == IDLE) || (bus.out_ready && !multi_p1));
  assign accept_p0 = bus.in_valid && ready_p0;

  // ---- stage p1: held op, FSM and busy counter ----
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_p1 <= IDLE;
      cnt_p1   <= 8'd0;
      vld_p1   <= 1'b0;
      busy_p1  <= 1'b0;
      multi_p1 <= 1'b0;
      alu_p1   <= '0;
    end else if (bus.flush) begin
      state_p1 <= IDLE;
      cnt_p1   <= 8'd0;
      vld_p1   <= 1'b0;
      busy_p1  <= 1'b0;
      multi_p1 <= 1'b0;
    end else begin
      case (state_p1)
        IDLE: begin
          if (accept_p0) begin
            state_p1 <= HOLD;
            vld_p1   <= 1'b1;
            alu_p1   <= xlate_p0;
            multi_p1 <= multi_p0;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            if (multi_p1) begin
              state_p1 <= WAIT;
              cnt_p1   <= 8'(MD_CYCLES);
              busy_p1  <= 1'b1;
              vld_p1   <= 1'b0;
              multi_p1 <= 1'b0;
            end else if (accept_p0) begin
              alu_p1   <= xlate_p0;
              multi_p1 <= multi_p0;
            end else begin
              state_p1 <= IDLE;
              vld_p1   <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (cnt_p1 == 8'd1) begin
            state_p1 <= IDLE;
            cnt_p1   <= 8'd0;
            busy_p1  <= 1'b0;
          end else begin
            cnt_p1 <= cnt_p1 - 8'd1;
          end
        end
        default: begin
          state_p1 <= IDLE;
          cnt_p1   <= 8'd0;
          vld_p1   <= 1'b0;
          busy_p1  <= 1'b0;
          multi_p1 <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = ready_p0;
  assign bus.out_valid  = vld_p1;
  assign bus.alu_opcode = alu_p1;
  assign bus.out_multi  = multi_p1;
  assign bus.busy       = busy_p1;

endmodule

// File: tb/tb_alu_control_pipe.sv
// Directed bench for alu_control_pipe: translation table plus stall, multi-cycle and flush sequences.
module tb_alu_control_pipe;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  alu_control_pipe_if #(.OPW(8)) bus ();

  alu_control_pipe #(
    .OPW       (8),
    .ADDU_CODE (8'h06),
    .MD_CLASS  (4'b1100),
    .MD_CYCLES (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] op;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.in_valid  = 1'b1;
    bus.opcode    = 8'h03;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    vecs[0]  = '{8'h03, 8'h03};
    vecs[1]  = '{8'h4C, 8'h06};
    vecs[2]  = '{8'h48, 8'h06};
    vecs[3]  = '{8'h45, 8'h45};
    vecs[4]  = '{8'h81, 8'h81};
    vecs[5]  = '{8'hF2, 8'hF2};
    vecs[6]  = '{8'h2A, 8'h02};
    vecs[7]  = '{8'h00, 8'h00};
    vecs[8]  = '{8'h4F, 8'h4F};
    vecs[9]  = '{8'h8C, 8'h8C};
    vecs[10] = '{8'hFF, 8'hFF};
    vecs[11] = '{8'hB7, 8'h0B};

    // Reset held for two edges with in_valid asserted
    @(negedge clock);
    step();
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_alu", 32'(bus.alu_opcode), 32'h00);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_multi", 32'(bus.out_multi), 32'd0);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Back-to-back stream, one result per cycle
    bus.in_valid = 1'b1;
    bus.opcode   = vecs[0].op;
    step();
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("stream_valid[%0d]", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("stream_alu[%0d]", i), 32'(bus.alu_opcode), 32'(vecs[i].exp));
      chk($sformatf("stream_multi[%0d]", i), 32'(bus.out_multi), 32'd0);
      if (i < 11) begin
        bus.opcode = vecs[i+1].op;
        #1;
        chk($sformatf("stream_ready[%0d]", i), 32'(bus.in_ready), 32'd1);
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
    end
    chk("drain_valid", 32'(bus.out_valid), 32'd0);
    chk("drain_retain", 32'(bus.alu_opcode), 32'h0B);

    // Backpressure: 07 held for 3 stalled cycles, then handoff with same-edge accept of 10
    bus.in_valid  = 1'b1;
    bus.opcode    = 8'h07;
    bus.out_ready = 1'b0;
    step();
    bus.opcode = 8'h10;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall_alu[%0d]", i), 32'(bus.alu_opcode), 32'h07);
      chk($sformatf("stall_valid[%0d]", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("stall_ready[%0d]", i), 32'(bus.in_ready), 32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("stall_release_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("stall_next_valid", 32'(bus.out_valid), 32'd1);
    chk("stall_next_alu", 32'(bus.alu_opcode), 32'h01);
    step();
    chk("stall_drain_valid", 32'(bus.out_valid), 32'd0);

    // Multi-cycle op: busy for exactly 4 cycles after handoff
    bus.in_valid = 1'b1;
    bus.opcode   = 8'hC3;
    step();
    chk("md_valid", 32'(bus.out_valid), 32'd1);
    chk("md_alu", 32'(bus.alu_opcode), 32'hC3);
    chk("md_multi", 32'(bus.out_multi), 32'd1);
    bus.opcode = 8'h45;
    #1;
    chk("md_hold_ready", 32'(bus.in_ready), 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("md_busy[%0d]", i), 32'(bus.busy), 32'd1);
      chk($sformatf("md_ready[%0d]", i), 32'(bus.in_ready), 32'd0);
      chk($sformatf("md_nvalid[%0d]", i), 32'(bus.out_valid), 32'd0);
      step();
    end
    chk("md_busy_end", 32'(bus.busy), 32'd0);
    chk("md_ready_back", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("md_next_valid", 32'(bus.out_valid), 32'd1);
    chk("md_next_alu", 32'(bus.alu_opcode), 32'h45);
    step();

    // Flush during the second busy cycle
    bus.in_valid = 1'b1;
    bus.opcode   = 8'hC3;
    step();
    bus.in_valid = 1'b0;
    step();
    chk("fw_busy1", 32'(bus.busy), 32'd1);
    step();
    chk("fw_busy2", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    #1;
    chk("fw_flush_ready", 32'(bus.in_ready), 32'd0);
    step();
    chk("fw_busy_cleared", 32'(bus.busy), 32'd0);
    bus.flush = 1'b0;
    #1;
    chk("fw_ready_after", 32'(bus.in_ready), 32'd1);

    // Flush against a held op with 22 offered in the same cycle
    bus.in_valid  = 1'b1;
    bus.opcode    = 8'h07;
    bus.out_ready = 1'b0;
    step();
    chk("fh_held", 32'(bus.out_valid), 32'd1);
    bus.opcode = 8'h22;
    bus.flush  = 1'b1;
    #1;
    chk("fh_flush_ready", 32'(bus.in_ready), 32'd0);
    step();
    chk("fh_cleared", 32'(bus.out_valid), 32'd0);
    chk("fh_multi", 32'(bus.out_multi), 32'd0);
    bus.flush = 1'b0;
    #1;
    chk("fh_ready_after", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("fh_late_valid", 32'(bus.out_valid), 32'd1);
    chk("fh_late_alu", 32'(bus.alu_opcode), 32'h02);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
